// File: rtl/neuro_pkg.sv
// Shared address-event (AER) definitions for the neuromorphic fabric.
// Pure types and constants: no latency, no backpressure.
package neuro_pkg;
    localparam int ID_WIDTH     = 3;
    localparam int TS_WIDTH     = 16;
    localparam int DROP_CNT_MAX = 255;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [TS_WIDTH-1:0] ts;
    } aer_event_t;
endpackage

// File: rtl/spike_event_arbiter_rr.sv
// Round-robin picker: scans upward from last_grant_i+1 (mod N), first request wins.
// Purely combinational; en_i low suppresses every grant.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_grant_o
);
    int          cand_w;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_o       = '0;
        idx_o       = '0;
        any_grant_o = 1'b0;
        cand_w      = 0;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            cand_w = (int'(last_grant_i) + k) % N;
            cand   = IW'(cand_w);
            if (en_i && !any_grant_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_grant_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spike_event_arbiter.sv
// Serialises neuron spike pulses into AER {id, ts} events; spike to aer_valid is 2 cycles.
// Valid/ready output register; a busy register stalls grants while spikes keep being captured.
module spike_event_arbiter #(
    parameter int NUM_NEURONS = 8,
    parameter int ID_WIDTH    = neuro_pkg::ID_WIDTH,
    parameter int TS_WIDTH    = neuro_pkg::TS_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_NEURONS-1:0] spike_in,
    output logic                   aer_valid,
    input  logic                   aer_ready,
    output logic [ID_WIDTH-1:0]    aer_id,
    output logic [TS_WIDTH-1:0]    aer_ts,
    output logic [7:0]             drop_count,
    input  logic                   drop_clr
);
    import neuro_pkg::*;

    localparam logic [ID_WIDTH-1:0] LAST_RST = ID_WIDTH'(NUM_NEURONS - 1);

    logic [NUM_NEURONS-1:0] pending_q, pending_d;
    logic [NUM_NEURONS-1:0] gnt, drops;
    logic [ID_WIDTH-1:0]    last_grant_q, last_grant_d, win_idx;
    logic [TS_WIDTH-1:0]    ts_q;
    logic                   aer_valid_q, aer_valid_d;
    logic [ID_WIDTH-1:0]    aer_id_q, aer_id_d;
    logic [TS_WIDTH-1:0]    aer_ts_q, aer_ts_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;
    logic [9:0]             drop_sum;
    logic                   out_free, any_grant;

    // The output register can take a new event when empty or draining this cycle.
    assign out_free = !aer_valid_q || aer_ready;

    rr_arbiter #(
        .N  (NUM_NEURONS),
        .IW (ID_WIDTH)
    ) u_rr (
        .req_i        (pending_q),
        .last_grant_i (last_grant_q),
        .en_i         (enable && out_free),
        .gnt_o        (gnt),
        .idx_o        (win_idx),
        .any_grant_o  (any_grant)
    );

    always_comb begin
        // A spike landing on its own grant cycle re-arms the bit as a fresh event.
        pending_d    = (pending_q & ~gnt) | spike_in;
        drops        = spike_in & pending_q & ~gnt;
        drop_sum     = 10'(drop_cnt_q) + 10'($countones(drops));
        if (drop_clr)
            drop_cnt_d = '0;
        else if (drop_sum > 10'(DROP_CNT_MAX))
            drop_cnt_d = 8'(DROP_CNT_MAX);
        else
            drop_cnt_d = drop_sum[7:0];

        last_grant_d = any_grant ? win_idx : last_grant_q;
        aer_valid_d  = aer_valid_q;
        aer_id_d     = aer_id_q;
        aer_ts_d     = aer_ts_q;
        if (any_grant) begin
            aer_valid_d = 1'b1;
            aer_id_d    = win_idx;
            aer_ts_d    = ts_q;
        end else if (aer_valid_q && aer_ready) begin
            aer_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            ts_q         <= '0;
            last_grant_q <= LAST_RST;
            aer_valid_q  <= 1'b0;
            aer_id_q     <= '0;
            aer_ts_q     <= '0;
            drop_cnt_q   <= '0;
        end else begin
            pending_q    <= pending_d;
            ts_q         <= ts_q + 1'b1;
            last_grant_q <= last_grant_d;
            aer_valid_q  <= aer_valid_d;
            aer_id_q     <= aer_id_d;
            aer_ts_q     <= aer_ts_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign aer_valid  = aer_valid_q;
    assign aer_id     = aer_id_q;
    assign aer_ts     = aer_ts_q;
    assign drop_count = drop_cnt_q;
endmodule
